load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and datamemory. Datamemory is word-addressed, supports full-word writes only, and has a synchronous read.
- Converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses.
- Sub-word stores use a read-modify-write sequence.
- Applies sign/zero extension to loads and flags misaligned or reserved-size requests.
- Drives a busy signal that stalls the pipeline while an access is in flight.

Parameters:
- DATA_WIDTH, 32, word width; must be 32.
- ADDR_WIDTH, 10, datamemory word-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present; held stable by requester until accepted.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend the load (lbu/lhu); ignored for stores and words.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from the low bits.
- busy  out  1  unit not in IDLE; a request is accepted only when busy=0.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and faults.
- fault  out  1  pulses with resp_valid for misaligned or reserved-size requests.
- mem_address  out  ADDR_WIDTH  word address to datamemory.
- mem_we  out  1  datamemory write enable.
- mem_in  out  32  datamemory write data.
- mem_out  in  32  datamemory read data, valid the cycle after the address is sampled.

Behaviour:
- Reset values: state=IDLE, busy=0, resp_valid=0, resp_rdata=0, fault=0.
- While rst=1, mem_we is forced to 0 combinationally. A reset during any state drops the in-flight access: no write, no response.
- Word address = req_addr[ADDR_WIDTH+1:2]. Higher address bits are ignored (wrap).
- Lane mapping is big-endian (MIPS):
  - byte offset 0 = bits 31:24, offset 3 = bits 7:0.
  - half offset 0 = bits 31:16, offset 2 = bits 15:0.
- Alignment rules:
  - half requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size 11 always faults.
- Accept cycle T = cycle with req_valid=1, busy=0, in IDLE. The request is captured into internal registers at the end of T.
- In IDLE, mem_address is driven combinationally from req_addr. In all other states it is driven from the captured address.
- FSM states: IDLE, LD_CAPTURE, RMW_MERGE, RMW_WRITE.
  - Fault: at T no memory access, mem_we=0. Stay in IDLE. At T+1: resp_valid=1, fault=1, resp_rdata=0.
  - sw: at T mem_we=1, mem_in=req_wdata (datamemory writes at the end of T). Stay in IDLE. At T+1: resp_valid=1.
  - Load (lb/lbu/lh/lhu/lw): IDLE -> LD_CAPTURE.
    - T+1: busy=1; mem_out is extracted and extended, then registered.
    - T+2: IDLE, resp_valid=1, resp_rdata=result.
    - Latency is 2 cycles.
  - sb/sh: IDLE -> RMW_MERGE -> RMW_WRITE -> IDLE.
    - T+1: busy=1; mem_out is merged with the new lane and registered.
    - T+2: busy=1, mem_we=1, mem_in=merged word.
    - T+3: resp_valid=1.
- Back-to-back operation: a new request may be accepted in the same cycle resp_valid is high, since the FSM is already in IDLE.
- mem_we is never asserted outside sw-in-IDLE and RMW_WRITE.
- Extension:
  - Signed byte/half loads replicate the MSB of the selected lane.
  - Unsigned loads fill with zeros.
  - lw ignores req_unsigned.
- mem_in holds 0 whenever mem_we=0.

Decomposition:
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - FSM state encoding (2-bit localparams).
- One combinational sub-module, byte_lane_unit. It takes word, offset[1:0], size, unsigned, and wdata, and produces the extended load value and the merged store word. The FSM and registers stay in load_store_unit.

Test Plan:
- Word store: sw 0xDEADBEEF to 0x10 -> mem_we=1, mem_address=4 at T; resp_valid at T+1, fault=0; lw 0x10 -> resp_rdata=0xDEADBEEF at T+2.
- Byte loads on 0xDEADBEEF at word 4:
  - lb 0x11 -> 0xFFFFFFAD.
  - lbu 0x11 -> 0x000000AD.
  - lb 0x13 -> 0xFFFFFFEF.
  - lh 0x12 -> 0xFFFFBEEF.
  - lhu 0x10 -> 0x0000DEAD.
- Sub-word stores:
  - sh 0x1234 to 0x12 -> busy for 2 cycles, single mem_we at T+2 with mem_in=0xDEAD1234; lw 0x10 -> 0xDEAD1234.
  - sb 0x55 to 0x10 -> later lw returns 0x55AD1234.
- Faults: lh 0x13, lw 0x12, size=11 at 0x10 -> resp_valid and fault at T+1; mem_we never asserted; memory unchanged.
- Reset mid-RMW: sb 0xFF to 0x10, assert rst during the RMW_MERGE cycle -> no mem_we, busy=0 and resp_valid=0 after reset; lw 0x10 returns the old value.
- Back-to-back: sw then lw to the same word issued on consecutive accept cycles -> lw returns the newly stored data; resp_valid pulses at T+1 and T'+2.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS load/store path to datamemory.
// Access sizes, LSU FSM states and the captured-request bundle.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LD_CAPTURE = 2'd1;
    localparam logic [1:0] ST_RMW_MERGE  = 2'd2;
    localparam logic [1:0] ST_RMW_WRITE  = 2'd3;

    typedef struct packed {
        logic [1:0]  offset;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_fault(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        case (size)
            SZ_BYTE: is_fault = 1'b0;
            SZ_HALF: is_fault = offset[0];
            SZ_WORD: is_fault = |offset;
            default: is_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Big-endian lane select/extend for loads and lane merge for stores.
// Purely combinational; offset 0 is the most significant byte.
module byte_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [4:0]  bpos;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // byte lane n sits at bit 8*(3-n)
    assign bpos     = {~offset, 3'b000};
    assign sel_byte = word[bpos +: 8];
    assign sel_half = offset[1] ? word[15:0] : word[31:16];

    always_comb begin
        load_val = word;
        case (size)
            SZ_BYTE: begin
                if (is_unsigned)
                    load_val = {24'h0, sel_byte};
                else
                    load_val = {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                if (is_unsigned)
                    load_val = {16'h0, sel_half};
                else
                    load_val = {{16{sel_half[15]}}, sel_half};
            end
            default: load_val = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[bpos +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (offset[1])
                    merged[15:0] = wdata[15:0];
                else
                    merged[31:16] = wdata[15:0];
            end
            SZ_WORD: merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only datamemory.
// Sub-word stores go through a read-modify-write of the whole word.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    lsu_req_t              req_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [31:0]           lane_load;
    logic [31:0]           lane_merged;

    logic accept;
    logic req_bad;
    logic do_fault;
    logic do_load;
    logic do_sw;
    logic do_rmw;
    logic unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign busy    = (state != ST_IDLE);
    assign accept  = req_valid && (state == ST_IDLE);
    assign req_bad = is_fault(req_size, req_addr[1:0]);

    assign do_fault = accept && req_bad;
    assign do_load  = accept && !req_bad && !req_write;
    assign do_sw    = accept && !req_bad && req_write
                    && (req_size == SZ_WORD);
    assign do_rmw   = accept && !req_bad && req_write
                    && (req_size != SZ_WORD);

    assign mem_address = (state == ST_IDLE)
                       ? req_addr[ADDR_WIDTH+1:2]
                       : addr_q;

    // reset must cancel a pending write in the same cycle
    always_comb begin
        mem_we = 1'b0;
        mem_in = '0;
        if (!rst) begin
            if (do_sw) begin
                mem_we = 1'b1;
                mem_in = req_wdata;
            end else if (state == ST_RMW_WRITE) begin
                mem_we = 1'b1;
                mem_in = merged_q;
            end
        end
    end

    byte_lane_unit u_lane (
        .word        (mem_out),
        .offset      (req_q.offset),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .load_val    (lane_load),
        .merged      (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            fault      <= 1'b0;
            addr_q     <= '0;
            req_q      <= '0;
            merged_q   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            fault      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr[ADDR_WIDTH+1:2];
                        req_q  <= '{
                            offset:      req_addr[1:0],
                            size:        req_size,
                            is_unsigned: req_unsigned,
                            wdata:       req_wdata
                        };
                    end
                    unique case (1'b1)
                        do_fault: begin
                            resp_valid <= 1'b1;
                            fault      <= 1'b1;
                        end
                        do_load: state <= ST_LD_CAPTURE;
                        do_sw:   resp_valid <= 1'b1;
                        do_rmw:  state <= ST_RMW_MERGE;
                        default: state <= ST_IDLE;
                    endcase
                end
                ST_LD_CAPTURE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= lane_load;
                    state      <= ST_IDLE;
                end
                ST_RMW_MERGE: begin
                    merged_q <= lane_merged;
                    state    <= ST_RMW_WRITE;
                end
                ST_RMW_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-array memory model.
// Includes a simple synchronous-read datamemory behind the unit.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic [9:0]  mem_address;
    logic        mem_we;
    logic [31:0] mem_in;
    logic [31:0] mem_out = '0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .fault        (fault),
        .mem_address  (mem_address),
        .mem_we       (mem_we),
        .mem_in       (mem_in),
        .mem_out      (mem_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] dmem [1024];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_address] <= mem_in;
        mem_out <= dmem[mem_address];
    end

    // reference: flat byte memory, big-endian words, 4 KiB wrap
    logic [7:0] mb [4096];

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          c;
    } rsp_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int b);
        return {mb[b], mb[b+1], mb[b+2], mb[b+3]};
    endfunction

    function automatic logic ref_bad(input logic [1:0] sz,
                                     input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                             input logic u,
                                             input logic [31:0] a);
        int b;
        logic [15:0] h;
        b = int'(a % 4096);
        case (sz)
            2'd0: return u ? {24'h0, mb[b]} : {{24{mb[b][7]}}, mb[b]};
            2'd1: begin
                h = {mb[b], mb[b+1]};
                return u ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return ref_word(b);
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
        int b;
        b = int'(a % 4096);
        case (sz)
            2'd0: mb[b] = d[7:0];
            2'd1: begin
                mb[b]   = d[15:8];
                mb[b+1] = d[7:0];
            end
            default: begin
                mb[b]   = d[31:24];
                mb[b+1] = d[23:16];
                mb[b+2] = d[15:8];
                mb[b+3] = d[7:0];
            end
        endcase
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
        end
        chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
        int t;
        int b;
        rsp_t r;
        wr_t  x;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        drive(w, sz, u, a, d);
        t = cyc;
        r.d = 32'h0;
        r.f = 1'b0;
        if (ref_bad(sz, a)) begin
            r.f = 1'b1;
            r.c = t + 1;
        end else if (!w) begin
            r.d = ref_load(sz, u, a);
            r.c = t + 2;
        end else begin
            ref_store(sz, a, d);
            b = int'(a % 4096);
            x.a = 10'(b / 4);
            x.d = ref_word(b - (b % 4));
            x.c = (sz == 2'd2) ? t : t + 2;
            wq.push_back(x);
            r.c = (sz == 2'd2) ? t + 1 : t + 3;
        end
        rq.push_back(r);
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("queue_drain", 32'(rq.size() + wq.size()), 32'd0);
    endtask

    // stage 1 = reset in the merge cycle, 2 = in the write cycle
    task automatic rmw_reset(input int stage);
        drain();
        wait_idle();
        drive(1'b1, 2'd0, 1'b0, 32'h10, 32'hFF);
        @(negedge clk);
        req_valid = 1'b0;
        if (stage == 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    always begin
        rsp_t r;
        wr_t  x;
        @(negedge clk);
        #2;
        if (resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                r = rq.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(r.c));
                chk("resp_rdata", resp_rdata, r.d);
                chk("resp_fault", 32'(fault), 32'(r.f));
            end
        end else if (!rst) begin
            chk("fault_idle", 32'(fault), 32'd0);
        end
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("we_unexpected", 32'(mem_we), 32'd0);
            end else begin
                x = wq.pop_front();
                chk("we_cycle", 32'(cyc), 32'(x.c));
                chk("we_addr", 32'(mem_address), 32'(x.a));
                chk("we_data", mem_in, x.d);
            end
        end else if (!rst) begin
            chk("mem_in_idle", mem_in, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        for (int i = 0; i < 4096; i++) mb[i] = '0;

        repeat (3) @(negedge clk);
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);

        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
        @(negedge clk);
        req_valid = 1'b0;
        #2 chk("sh_busy_t1", 32'(busy), 32'd1);
        @(negedge clk);
        #2 chk("sh_busy_t2", 32'(busy), 32'd1);
        @(negedge clk);
        #2 chk("sh_busy_t3", 32'(busy), 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h55);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h11111111);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h22222222);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        rmw_reset(1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        rmw_reset(2);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                req_valid = 1'b0;
            end
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  (32'($urandom) & 32'hFFFFF000)
                  | 32'($urandom_range(0, 63)),
                  32'($urandom));
        end

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
